gf8_operand_sequencer: RTL and testbench
========================================

// Module: gf8_operand_sequencer
// PURPOSE
//  Upstream feeder for the GF(2^8) 4-term matrix-vector multiply-accumulate stage.
//  Holds a 4x4 matrix M and a 4-element vector V, loaded through a simple write port.
//  On start it streams the 16 operand pairs (M[r][c], V[c]) one per clock, row-major.
//  Framing strobes mark the first and last term of each row's dot product.
// PARAMETERS
//  W    8   element width in bits; GF(2^8), fixed at 8 for this design
//  N    4   matrix dimension and terms per dot product; must match downstream accumulator depth
// PORTS
//  clk       in   1     rising-edge clock
//  reset     in   1     asynchronous, active-high reset
//  wr_en     in   1     write strobe, honoured only in IDLE
//  wr_sel    in   1     0: write M, 1: write V
//  wr_addr   in   4     M index = row*4+col; V index = wr_addr[1:0] (upper bits ignored)
//  wr_data   in   8     element value
//  start     in   1     begin a run, honoured only in IDLE
//  busy      out  1     high while state is RUN or DONE
//  done      out  1     one-cycle pulse at end of run
//  a_out     out  8     matrix operand M[row_idx][col]
//  b_out     out  8     vector operand V[col]
//  op_valid  out  1     a_out/b_out valid this cycle
//  op_first  out  1     col==0 term (clear accumulator)
//  op_last   out  1     col==3 term (dot product complete)
//  row_idx   out  2     row of the current term
// BEHAVIOUR
//  - Reset (async, any state): M, V, 4-bit term counter all cleared to 0; state=IDLE.
//    All outputs go to 0 immediately.
//    A run in progress is aborted with no done pulse.
//  - States: IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
//    busy is decoded from the state register only.
//  - IDLE:
//    - wr_en writes wr_data into M or V at the clock edge.
//    - start=1 at edge k: state<=RUN, counter<=0. No operand is emitted at edge k.
//    - wr_en and start together at edge k: the write commits at k and is seen by the run.
//  - RUN: at each edge, with counter t (row=t[3:2], col=t[1:0]):
//    - a_out<=M[row][col], b_out<=V[col], op_valid<=1, op_first<=(col==0),
//      op_last<=(col==3), row_idx<=row; then t<=t+1.
//    - Edges k+1..k+16 emit terms 0..15 with no gaps.
//    - At t==15 (edge k+16): state<=DONE.
//  - DONE, edge k+17:
//    - op_valid, op_first and op_last <= 0; a_out, b_out and row_idx <= 0; done<=1.
//    - state<=IDLE, so busy is low in the cycle where done is high.
//    - Edge k+18: done<=0.
//  - wr_en or start while busy: ignored. Storage and the run are unaffected; no error flag.
//  - start held high continuously: the next run is accepted at edge k+18.
//    op_valid is then low for 2 cycles between runs.
//  - The counter wraps from 15 to 0 only through the DONE exit; no partial rows are ever emitted.
//  - Storage persists across runs until it is overwritten or reset.
// TESTING
//  1. Assert reset mid-clock -> busy, done, op_* and a_out/b_out = 0 immediately; a later run emits all-zero operands.
//  2. Load M=identity, V={01,02,03,04}; start -> row 0 pairs (01,01),(00,02),(00,03),(00,04);
//     op_first on term 0, op_last on term 3; 16 contiguous valids; done exactly 17 cycles after the start edge.
//  3. During a run, pulse start and write M[0]=FF -> the run is unchanged and the next run still shows M[0]=01.
//  4. In IDLE, assert wr_en (V[0]=55) and start on the same edge -> the first b_out is 55.
//  5. Assert reset after term 7 -> outputs 0 at once, no done pulse, busy=0, and M/V read back as 0 on the next run.
//  6. Hold start high through two runs -> the second run's first op_valid comes 19 cycles after the first run's start edge.

Source files
------------

// File: rtl/gf8_operand_sequencer.sv
// Operand feeder for a GF(2^8) 4-term matrix-vector MAC: holds a 4x4 matrix M
// and a 4-element vector V, then streams (M[r][c], V[c]) row-major, one pair per clock.
module gf8_operand_sequencer #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic         wr_sel,
  input  logic [3:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic         op_valid,
  output logic         op_first,
  output logic         op_last,
  output logic [1:0]   row_idx
);

  localparam int unsigned TW       = 4;
  localparam int unsigned NTERMS   = N * N;
  localparam logic [TW-1:0] T_LAST = TW'(NTERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] cnt, cnt_d;
  logic [W-1:0]  mat [NTERMS];
  logic [W-1:0]  vec [N];

  logic          wr_m, wr_v;
  logic [W-1:0]  a_d, b_d;
  logic          valid_d, first_d, last_d, done_d;
  logic [1:0]    row_d;

  // Busy is a pure decode of the state register.
  assign busy = (state != S_IDLE);

  // State and term counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state, write enables and next operand values.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr_m    = 1'b0;
    wr_v    = 1'b0;
    a_d     = '0;
    b_d     = '0;
    valid_d = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    row_d   = '0;
    done_d  = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A write on the start edge commits before the first operand read.
        wr_m = wr_en & ~wr_sel;
        wr_v = wr_en &  wr_sel;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_d     = mat[cnt];
        b_d     = vec[cnt[1:0]];
        valid_d = 1'b1;
        first_d = (cnt[1:0] == 2'd0);
        last_d  = (cnt[1:0] == 2'd3);
        row_d   = cnt[3:2];
        if (cnt == T_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Matrix and vector storage; persists across runs until overwritten or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTERMS; i++) mat[i] <= '0;
      for (int unsigned i = 0; i < N; i++)      vec[i] <= '0;
    end else begin
      if (wr_m) mat[wr_addr]      <= wr_data;
      if (wr_v) vec[wr_addr[1:0]] <= wr_data;
    end
  end

  // Registered operand stream and framing outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out    <= '0;
      b_out    <= '0;
      op_valid <= 1'b0;
      op_first <= 1'b0;
      op_last  <= 1'b0;
      row_idx  <= '0;
      done     <= 1'b0;
    end else begin
      a_out    <= a_d;
      b_out    <= b_d;
      op_valid <= valid_d;
      op_first <= first_d;
      op_last  <= last_d;
      row_idx  <= row_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_gf8_operand_sequencer.sv
// Directed bench for gf8_operand_sequencer: vector table for the identity load,
// shadow-storage expectations for the remaining multi-cycle sequences.
module tb_gf8_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy, done, op_valid, op_first, op_last;
  logic [7:0] a_out, b_out;
  logic [1:0] row_idx;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       first;
    logic       last;
    logic [1:0] row;
  } term_t;

  term_t      tbl   [16];
  term_t      exp_q [16];
  logic [7:0] sm    [16];
  logic [7:0] sv    [4];

  gf8_operand_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .a_out    (a_out),
    .b_out    (b_out),
    .op_valid (op_valid),
    .op_first (op_first),
    .op_last  (op_last),
    .row_idx  (row_idx)
  );

  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),     32'h0);
    chk({tag, "_done"},  32'(done),     32'h0);
    chk({tag, "_valid"}, 32'(op_valid), 32'h0);
    chk({tag, "_first"}, 32'(op_first), 32'h0);
    chk({tag, "_last"},  32'(op_last),  32'h0);
    chk({tag, "_a"},     32'(a_out),    32'h0);
    chk({tag, "_b"},     32'(b_out),    32'h0);
    chk({tag, "_row"},   32'(row_idx),  32'h0);
  endtask

  // Idle-only write; mirrors into the shadow storage.
  task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) sv[addr[1:0]] = data;
    else     sm[addr]      = data;
  endtask

  task automatic build_exp();
    for (int i = 0; i < 16; i++) begin
      exp_q[i].a     = sm[i];
      exp_q[i].b     = sv[i % 4];
      exp_q[i].first = ((i % 4) == 0);
      exp_q[i].last  = ((i % 4) == 3);
      exp_q[i].row   = 2'(i / 4);
    end
  endtask

  // Start edge k; returns at the negedge after k.
  task automatic do_start(input bit hold);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("start_busy",  32'(busy),     32'h1);
    chk("start_valid", 32'(op_valid), 32'h0);
  endtask

  // Checks edges k+1..k+18; optional mid-run injection of start+write, optional reset abort.
  task automatic run_body(input int inject_at, input int abort_at);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == inject_at + 1) begin start = 1'b0; wr_en = 1'b0; end
      chk($sformatf("t%0d_a", j-1),     32'(a_out),    32'(exp_q[j-1].a));
      chk($sformatf("t%0d_b", j-1),     32'(b_out),    32'(exp_q[j-1].b));
      chk($sformatf("t%0d_valid", j-1), 32'(op_valid), 32'h1);
      chk($sformatf("t%0d_first", j-1), 32'(op_first), 32'(exp_q[j-1].first));
      chk($sformatf("t%0d_last", j-1),  32'(op_last),  32'(exp_q[j-1].last));
      chk($sformatf("t%0d_row", j-1),   32'(row_idx),  32'(exp_q[j-1].row));
      chk($sformatf("t%0d_busy", j-1),  32'(busy),     32'h1);
      chk($sformatf("t%0d_done", j-1),  32'(done),     32'h0);
      if (j == abort_at) begin
        #2 reset = 1'b1;
        #1 chk_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("abort_nodone", 32'(done), 32'h0);
          chk("abort_busy",   32'(busy), 32'h0);
        end
        return;
      end
      if (j == inject_at) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'hFF;
      end
    end
    @(negedge clk);
    chk("end_done",  32'(done),     32'h1);
    chk("end_busy",  32'(busy),     32'h0);
    chk("end_valid", 32'(op_valid), 32'h0);
    chk("end_first", 32'(op_first), 32'h0);
    chk("end_last",  32'(op_last),  32'h0);
    chk("end_a",     32'(a_out),    32'h0);
    chk("end_b",     32'(b_out),    32'h0);
    chk("end_row",   32'(row_idx),  32'h0);
    @(negedge clk);
    chk("end_done_clr", 32'(done), 32'h0);
  endtask

  initial begin
    // Identity matrix, V = {01,02,03,04}: term table (a, b, first, last, row).
    tbl[0]  = '{8'h01, 8'h01, 1'b1, 1'b0, 2'd0};
    tbl[1]  = '{8'h00, 8'h02, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{8'h00, 8'h03, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{8'h00, 8'h04, 1'b0, 1'b1, 2'd0};
    tbl[4]  = '{8'h00, 8'h01, 1'b1, 1'b0, 2'd1};
    tbl[5]  = '{8'h01, 8'h02, 1'b0, 1'b0, 2'd1};
    tbl[6]  = '{8'h00, 8'h03, 1'b0, 1'b0, 2'd1};
    tbl[7]  = '{8'h00, 8'h04, 1'b0, 1'b1, 2'd1};
    tbl[8]  = '{8'h00, 8'h01, 1'b1, 1'b0, 2'd2};
    tbl[9]  = '{8'h00, 8'h02, 1'b0, 1'b0, 2'd2};
    tbl[10] = '{8'h01, 8'h03, 1'b0, 1'b0, 2'd2};
    tbl[11] = '{8'h00, 8'h04, 1'b0, 1'b1, 2'd2};
    tbl[12] = '{8'h00, 8'h01, 1'b1, 1'b0, 2'd3};
    tbl[13] = '{8'h00, 8'h02, 1'b0, 1'b0, 2'd3};
    tbl[14] = '{8'h00, 8'h03, 1'b0, 1'b0, 2'd3};
    tbl[15] = '{8'h01, 8'h04, 1'b0, 1'b1, 2'd3};
    for (int i = 0; i < 16; i++) sm[i] = 8'h00;
    for (int i = 0; i < 4; i++)  sv[i] = 8'h00;

    // 1: reset asserted mid-clock clears outputs at once; a run then emits zeros.
    #3 reset = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");
    build_exp();
    do_start(1'b0);
    run_body(-1, -1);

    // 2: identity matrix checked against the vector table.
    for (int i = 0; i < 16; i++) wr(1'b0, 4'(i), ((i / 4) == (i % 4)) ? 8'h01 : 8'h00);
    for (int i = 0; i < 4; i++)  wr(1'b1, 4'(i), 8'(i + 1));
    for (int i = 0; i < 16; i++) exp_q[i] = tbl[i];
    do_start(1'b0);
    run_body(-1, -1);

    // 3: start and M[0]=FF during a run are ignored; next run still sees M[0]=01.
    build_exp();
    do_start(1'b0);
    run_body(5, -1);
    do_start(1'b0);
    run_body(-1, -1);

    // 4: write V[0]=55 on the start edge; the run sees it.
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 8'h55; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    sv[0] = 8'h55;
    chk("ws_busy", 32'(busy), 32'h1);
    build_exp();
    run_body(-1, -1);

    // 5: reset after term 7 aborts the run and clears storage.
    do_start(1'b0);
    run_body(-1, 8);
    for (int i = 0; i < 16; i++) sm[i] = 8'h00;
    for (int i = 0; i < 4; i++)  sv[i] = 8'h00;
    build_exp();
    do_start(1'b0);
    run_body(-1, -1);

    // 6: start held high runs back to back with a two-cycle op_valid gap.
    for (int i = 0; i < 16; i++) wr(1'b0, 4'(i), 8'(8'h10 + i));
    wr(1'b1, 4'd0, 8'hA0);
    wr(1'b1, 4'd1, 8'hB1);
    wr(1'b1, 4'd2, 8'hC2);
    wr(1'b1, 4'd3, 8'hD3);
    build_exp();
    do_start(1'b1);
    run_body(-1, -1);
    chk("b2b_busy",  32'(busy),     32'h1);
    chk("b2b_valid", 32'(op_valid), 32'h0);
    start = 1'b0;
    run_body(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
